muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: CLK and RESET.
REQ-002 CLK  in  1  rising-edge clock of the pipeline.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 StartE  in  1  M-extension op valid in Execute.
REQ-005 MDOpE  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SrcAE, SrcBE  in  32 each  forwarded operands (rs1, rs2).
REQ-007 FlushE  in  1  kill the op currently in Execute (branch/jump redirect).
REQ-008 StallMD  out  1  stall Fetch/Decode/Execute registers.
REQ-009 MDDoneE  out  1  one-cycle pulse; MDResultE valid.
REQ-010 MDResultE  out  32  result written into the Execute→Memory ALU result path.
REQ-011 Busy  out  1  high in RUN or DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with StartE=1 and FlushE=0 SHALL latch operands and op, clear the iteration counter, and go to RUN; fast-path cases (REQ-019, REQ-020) SHALL go directly to DONE.
REQ-014 StallMD SHALL be combinational: 1 in IDLE when StartE=1 and FlushE=0, and 1 in RUN; 0 in DONE and otherwise.
REQ-015 RUN SHALL perform one iteration per cycle for exactly 32 cycles, using a 6-bit counter; after the iteration with counter=31 the next state SHALL be DONE.
REQ-016 Multiply SHALL be shift-add on operand magnitudes with a 64-bit product; MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]; signedness follows RISC-V (MULHSU: rs1 signed, rs2 unsigned); negation SHALL be applied to the 64-bit result.
REQ-017 Divide SHALL be restoring division on magnitudes; the quotient sign is the XOR of the operand signs, and the remainder sign is the sign of the dividend (signed ops only).
REQ-018 Normal latency: StartE sampled in cycle N, MDDoneE=1 in cycle N+33, and StallMD high in cycles N..N+32.
REQ-019 Divide by zero SHALL use the fast path (MDDoneE in N+1): DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
REQ-020 Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) SHALL use the fast path: DIV gives 0x80000000; REM gives 0.
REQ-021 DONE SHALL last one cycle, assert MDDoneE with MDResultE held from a result register, then go to IDLE; StartE in DONE SHALL be ignored.
REQ-022 FlushE=1 in RUN or DONE SHALL force IDLE on the next edge, suppress MDDoneE, and drop StallMD.
REQ-023 FlushE=1 with StartE=1 in IDLE SHALL NOT start an operation; flush wins.
REQ-024 MDResultE SHALL hold its last value outside DONE; consumers use it only when MDDoneE=1.
REQ-025 Back-to-back ops SHALL be accepted on the first IDLE cycle after DONE; there is no dead cycle beyond DONE.

Reset
REQ-026 RESET SHALL force IDLE and clear the counter, the operand, accumulator and result registers, and the latched op.
REQ-027 After reset: StallMD=0, MDDoneE=0, MDResultE=0, Busy=0.
REQ-028 RESET during RUN or DONE SHALL abort the operation with no MDDoneE pulse; RESET takes priority over FlushE and StartE.

Structure
REQ-029 Shared package muldiv_pkg SHALL hold the md_op_t enum (8 funct3 codes), the md_state_t enum (IDLE/RUN/DONE), and the constant MD_ITER=32.
REQ-030 One sub-module, muldiv_datapath, SHALL hold the magnitude/sign logic, the 64-bit accumulator, and the shift/subtract step; muldiv_sequencer holds the FSM, counter, fast-path detection, and handshake.

Verification
REQ-031 The bench SHALL cover MUL 7×6 → MDResultE=0x0000002A with MDDoneE in cycle N+33 and StallMD high for exactly 33 cycles.
REQ-032 The bench SHALL cover DIV −7/2 → 0xFFFFFFFD; REM −7,2 → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH −1×−1 → 0.
REQ-033 The bench SHALL cover DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each in cycle N+1, with StallMD high for one cycle.
REQ-034 The bench SHALL cover DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both on the fast path.
REQ-035 The bench SHALL cover FlushE at RUN iteration 10 → no MDDoneE, Busy=0 and StallMD=0 on the next cycle, and a following MUL 3×3 → 9 correct.
REQ-036 The bench SHALL cover RESET at iteration 20 → IDLE with all outputs 0 on the next cycle, and StartE+FlushE together in IDLE → no start, StallMD=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared types and constants for the M-extension multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_datapath
// Brief   : Magnitude/sign handling, 64-bit accumulator and shift-add /
//           restoring-divide step; o_finalNext is the signed result of the
//           accumulator value that the current step will produce.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_load,
    input  logic        i_step,
    input  md_op_t      i_op,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    output logic [31:0] o_finalNext
);

    md_op_t      r_op;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic        r_negQ;
    logic        r_negR;

    logic        w_signedA, w_signedB, w_negA, w_negB;
    logic [31:0] w_magA, w_magB;
    logic [32:0] w_sum, w_remShift, w_diff;
    logic [63:0] w_mulNext, w_divNext, w_accNext, w_prod;
    logic [31:0] w_quot, w_rem;

    always_comb begin
        w_signedA = (i_op == MD_MUL) || (i_op == MD_MULH) || (i_op == MD_MULHSU) ||
                    (i_op == MD_DIV) || (i_op == MD_REM);
        w_signedB = (i_op == MD_MUL) || (i_op == MD_MULH) ||
                    (i_op == MD_DIV) || (i_op == MD_REM);
        w_negA    = w_signedA & i_srcA[31];
        w_negB    = w_signedB & i_srcB[31];
        w_magA    = w_negA ? (32'd0 - i_srcA) : i_srcA;
        w_magB    = w_negB ? (32'd0 - i_srcB) : i_srcB;
    end

    // Multiply: add multiplicand to the high half, shift right with carry.
    // Divide: shift left, trial-subtract the divisor from the 33-bit remainder.
    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_mulNext  = {w_sum, r_acc[31:1]};
        w_remShift = r_acc[63:31];
        w_diff     = w_remShift - {1'b0, r_opnd};
        w_divNext  = w_diff[32] ? {r_acc[62:0], 1'b0}
                                : {w_diff[31:0], r_acc[30:0], 1'b1};
        w_accNext  = r_op[2] ? w_divNext : w_mulNext;
    end

    always_comb begin
        w_prod = r_negQ ? (64'd0 - w_accNext) : w_accNext;
        w_quot = r_negQ ? (32'd0 - w_accNext[31:0])  : w_accNext[31:0];
        w_rem  = r_negR ? (32'd0 - w_accNext[63:32]) : w_accNext[63:32];
        if (r_op[2])
            o_finalNext = r_op[1] ? w_rem : w_quot;
        else
            o_finalNext = (r_op == MD_MUL) ? w_prod[31:0] : w_prod[63:32];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op   <= MD_MUL;
            r_opnd <= 32'd0;
            r_acc  <= 64'd0;
            r_negQ <= 1'b0;
            r_negR <= 1'b0;
        end else if (i_load) begin
            r_op   <= i_op;
            r_opnd <= i_op[2] ? w_magB : w_magA;
            r_acc  <= {32'd0, i_op[2] ? w_magA : w_magB};
            r_negQ <= w_negA ^ w_negB;
            r_negR <= w_negA;
        end else if (i_step) begin
            r_acc  <= w_accNext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : IDLE/RUN/DONE control, iteration counter, divide fast paths and
//           pipeline stall/done handshake for the M-extension unit.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        StartE,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushE,
    output logic        StallMD,
    output logic        MDDoneE,
    output logic [31:0] MDResultE,
    output logic        Busy
);

    md_state_t   r_state;
    logic [5:0]  r_count;
    logic [31:0] r_result;

    logic        w_accept, w_step, w_divZero, w_overflow, w_fast;
    logic [31:0] w_fastResult, w_finalNext;

    always_comb begin
        w_accept     = (r_state == IDLE) & StartE & ~FlushE;
        w_step       = (r_state == RUN) & ~FlushE;
        w_divZero    = (SrcBE == 32'd0);
        w_overflow   = ((MDOpE == MD_DIV) || (MDOpE == MD_REM)) &&
                       (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
        w_fast       = MDOpE[2] & (w_divZero | w_overflow);
        if (w_divZero)
            w_fastResult = MDOpE[1] ? SrcAE : 32'hFFFF_FFFF;
        else
            w_fastResult = MDOpE[1] ? 32'd0 : 32'h8000_0000;
    end

    muldiv_datapath u_datapath (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_load      (w_accept),
        .i_step      (w_step),
        .i_op        (md_op_t'(MDOpE)),
        .i_srcA      (SrcAE),
        .i_srcB      (SrcBE),
        .o_finalNext (w_finalNext)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_count  <= 6'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= 6'd0;
                        if (w_fast) begin
                            r_result <= w_fastResult;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (FlushE) begin
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count + 6'd1;
                        if (r_count == 6'(MD_ITER - 1)) begin
                            r_result <= w_finalNext;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A flush or reset in the DONE cycle kills the completion pulse.
    assign StallMD   = w_accept | (r_state == RUN);
    assign MDDoneE   = (r_state == DONE) & ~FlushE & ~RESET;
    assign MDResultE = r_result;
    assign Busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_sequencer
// Brief   : Self-checking bench: vector table plus flush/reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        StartE = 1'b0;
    logic [2:0]  MDOpE = 3'd0;
    logic [31:0] SrcAE = 32'd0;
    logic [31:0] SrcBE = 32'd0;
    logic        FlushE = 1'b0;
    logic        StallMD, MDDoneE, Busy;
    logic [31:0] MDResultE;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sbQ[$];

    muldiv_sequencer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .StartE    (StartE),
        .MDOpE     (MDOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .StallMD   (StallMD),
        .MDDoneE   (MDDoneE),
        .MDResultE (MDResultE),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Issue one op at a negedge (cycle N) and follow it to MDDoneE.
    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        int   stalls = 0;
        int   doneAt = -1;
        exp_t e;
        @(negedge CLK);
        StartE = 1'b1; MDOpE = op; SrcAE = a; SrcBE = b;
        sbQ.push_back('{res: res, lat: lat});
        #1;
        if (StallMD) stalls++;
        @(posedge CLK);
        #1 StartE = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (MDDoneE) begin
                doneAt = k;
                break;
            end
            if (StallMD) stalls++;
        end
        e = sbQ.pop_front();
        if (doneAt < 0) begin
            nChecks++;
            $display("FAIL %s timeout: MDDoneE never seen within 60 cycles", name);
        end else begin
            check({name, " result"}, MDResultE, e.res);
        end
        check({name, " latency"}, 32'(doneAt), 32'(e.lat));
        check({name, " stall cycles"}, 32'(stalls), 32'(e.lat));
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{3'd0, 32'd7,          32'd6,          32'h0000_002A, 33},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33},
            '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33},
            '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1},
            '{3'd6, 32'd5,          32'd0,          32'h0000_0005, 1},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1},
            '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 33},
            '{3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 33},
            '{3'd5, 32'd100,        32'd7,          32'h0000_000E, 33},
            '{3'd7, 32'd100,        32'd7,          32'h0000_0002, 33},
            '{3'd6, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 33},
            '{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 33},
            '{3'd4, 32'h8000_0000,  32'd2,          32'hC000_0000, 33},
            '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33}
        };

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset StallMD", 32'(StallMD), 32'd0);
        check("reset MDDoneE", 32'(MDDoneE), 32'd0);
        check("reset MDResultE", MDResultE, 32'd0);
        check("reset Busy", 32'(Busy), 32'd0);

        foreach (vecs[i])
            runOp($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a,
                  vecs[i].b, vecs[i].res, vecs[i].lat);

        // Flush during RUN iteration 10.
        begin
            int doneSeen = 0;
            @(negedge CLK);
            StartE = 1'b1; MDOpE = 3'd0; SrcAE = 32'd11; SrcBE = 32'd13;
            @(posedge CLK);
            #1 StartE = 1'b0;
            repeat (11) @(negedge CLK);
            FlushE = 1'b1;
            @(posedge CLK);
            #1 FlushE = 1'b0;
            @(negedge CLK);
            check("flush Busy", 32'(Busy), 32'd0);
            check("flush StallMD", 32'(StallMD), 32'd0);
            for (int k = 0; k < 40; k++) begin
                @(negedge CLK);
                if (MDDoneE) doneSeen++;
            end
            check("flush no MDDoneE", 32'(doneSeen), 32'd0);
        end
        runOp("mul 3x3 after flush", 3'd0, 32'd3, 32'd3, 32'd9, 33);

        // Reset during RUN iteration 20.
        @(negedge CLK);
        StartE = 1'b1; MDOpE = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd3;
        @(posedge CLK);
        #1 StartE = 1'b0;
        repeat (21) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("mid-run reset StallMD", 32'(StallMD), 32'd0);
        check("mid-run reset MDDoneE", 32'(MDDoneE), 32'd0);
        check("mid-run reset MDResultE", MDResultE, 32'd0);
        check("mid-run reset Busy", 32'(Busy), 32'd0);

        // Start and flush together in IDLE: flush wins.
        StartE = 1'b1; FlushE = 1'b1; MDOpE = 3'd0; SrcAE = 32'd2; SrcBE = 32'd2;
        #1;
        check("start+flush StallMD", 32'(StallMD), 32'd0);
        @(posedge CLK);
        #1 StartE = 1'b0; FlushE = 1'b0;
        @(negedge CLK);
        check("start+flush Busy", 32'(Busy), 32'd0);

        runOp("mul after start+flush", 3'd0, 32'd12, 32'd12, 32'd144, 33);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
